// File: rtl/fan_ctrl_pkg.sv
// Shared types and constants for the multi-channel fan controller.
package fan_ctrl_pkg;

  localparam int DEF_CHANNELS      = 2;
  localparam int DEF_ADC_BITWIDTH  = 6;
  localparam int DEF_REG_BITWIDTH  = 14;
  localparam int DEF_FRAC_BITWIDTH = 6;

  localparam int MAC_TERMS = 5;

  localparam logic [3:0] STATE_CODE_RUN = 4'hA;
  localparam logic [3:0] STATE_CODE_CFG = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_SAT,
    ST_WRITE
  } fsm_state_e;

endpackage

// File: rtl/fan_pwm_bank.sv
// Shared PWM period counter with per-channel shadow/active compare registers.
module fan_pwm_bank #(
  parameter int CHANNELS = 2,
  parameter int CMP_W    = 7,
  parameter int CH_W     = 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                clk_en_i,
  input  logic [CMP_W-1:0]    period_i,
  input  logic                wr_en_i,
  input  logic [CH_W-1:0]     wr_ch_i,
  input  logic [CMP_W-1:0]    wr_cmp_i,
  output logic [CHANNELS-1:0] pin_o
);

  logic [CMP_W-1:0] cnt_q, cnt_d;
  logic [CMP_W-1:0] shadow_q [CHANNELS];
  logic [CMP_W-1:0] shadow_d [CHANNELS];
  logic [CMP_W-1:0] active_q [CHANNELS];
  logic [CMP_W-1:0] active_d [CHANNELS];
  logic             wrap;

  always_comb begin
    wrap     = (period_i != '0) && (cnt_q >= (period_i - CMP_W'(1)));
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    if (period_i == '0 || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CMP_W'(1);
    end
    // Actives only change at the wrap so a pulse is never cut short mid-period.
    if (wrap) begin
      active_d = shadow_q;
    end
    if (wr_en_i) begin
      shadow_d[wr_ch_i] = wr_cmp_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q    <= '0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else if (clk_en_i) begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    pin_o = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      pin_o[c] = (period_i != '0) && (cnt_q < active_q[c]);
    end
  end

endmodule

// File: rtl/fan_ctrl_multi.sv
// Multi-channel fan controller: per-channel biquad-style regulator sharing one
// multiplier, feeding a shared PWM bank.
module fan_ctrl_multi
  import fan_ctrl_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int ADC_BITWIDTH  = DEF_ADC_BITWIDTH,
  parameter int REG_BITWIDTH  = DEF_REG_BITWIDTH,
  parameter int FRAC_BITWIDTH = DEF_FRAC_BITWIDTH
) (
  input  logic                                          clk_i,
  input  logic                                          rstn_i,
  input  logic                                          clk_en_i,
  input  logic [ADC_BITWIDTH-1:0]                       data_i,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] channel_i,
  input  logic                                          dataValid_STRB_i,
  input  logic                                          config_en_i,
  input  logic signed [REG_BITWIDTH-1:0]                b2_i,
  input  logic signed [REG_BITWIDTH-1:0]                b1_i,
  input  logic signed [REG_BITWIDTH-1:0]                b0_i,
  input  logic signed [REG_BITWIDTH-1:0]                a1_i,
  input  logic signed [REG_BITWIDTH-1:0]                a0_i,
  input  logic [ADC_BITWIDTH:0]                         PWM_periodCounterValue_i,
  input  logic [ADC_BITWIDTH-1:0]                       PWM_minCounterValue_i,
  output logic [CHANNELS-1:0]                           PWM_pin_o,
  output logic                                          busy_o,
  output logic                                          overrun_o,
  output logic [3:0]                                    state_o
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int REG_W = REG_BITWIDTH;
  localparam int FRAC  = FRAC_BITWIDTH;
  localparam int ERR_W = ADC_BITWIDTH + 1;
  localparam int CMP_W = ADC_BITWIDTH + 1;
  localparam int INT_W = REG_W - FRAC;
  localparam int PRD_W = 2 * REG_W;
  localparam int ACC_W = 2 * REG_W + 3;

  fsm_state_e state_q, state_d;

  logic [2:0]                    term_q, term_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic signed [REG_W-1:0]       ecur_q, ecur_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic signed [REG_W-1:0]       y_q, y_d;
  logic [CMP_W-1:0]              cmp_q, cmp_d;
  logic                          ovr_q, ovr_d;

  logic [ADC_BITWIDTH-1:0]       sp_q [CHANNELS];
  logic [ADC_BITWIDTH-1:0]       sp_d [CHANNELS];
  logic signed [REG_W-1:0]       e1_q [CHANNELS];
  logic signed [REG_W-1:0]       e1_d [CHANNELS];
  logic signed [REG_W-1:0]       e2_q [CHANNELS];
  logic signed [REG_W-1:0]       e2_d [CHANNELS];
  logic signed [REG_W-1:0]       y1_q [CHANNELS];
  logic signed [REG_W-1:0]       y1_d [CHANNELS];
  logic signed [REG_W-1:0]       y2_q [CHANNELS];
  logic signed [REG_W-1:0]       y2_d [CHANNELS];

  logic                          ch_ok;
  logic                          strobe;
  logic                          wr_en;
  logic signed [ERR_W-1:0]       err_raw;
  logic signed [REG_W-1:0]       err_fx;
  logic signed [REG_W-1:0]       coef, opnd;
  logic signed [PRD_W-1:0]       prod;
  logic signed [ACC_W-1:0]       acc_sh;
  logic signed [REG_W-1:0]       ysat;
  logic signed [INT_W-1:0]       y_int;
  logic signed [INT_W-1:0]       period_ext;
  logic [CMP_W-1:0]              cmp_calc;

  if (CHANNELS == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (channel_i < CH_W'(CHANNELS));
  end

  assign strobe  = clk_en_i && dataValid_STRB_i && ch_ok;
  assign state_o = config_en_i ? STATE_CODE_CFG : STATE_CODE_RUN;

  // Error is ADC_BITWIDTH+1 bits; the width relation between REG and FRAC
  // guarantees the shifted value fits, so sign extension is exact saturation.
  always_comb begin
    err_raw = $signed({1'b0, sp_q[channel_i]}) - $signed({1'b0, data_i});
    err_fx  = $signed({{(REG_W - ERR_W){err_raw[ERR_W-1]}}, err_raw}) <<< FRAC;
  end

  always_comb begin
    coef = b2_i;
    opnd = ecur_q;
    case (term_q)
      3'd1:    begin coef = b1_i; opnd = e1_q[ch_q]; end
      3'd2:    begin coef = b0_i; opnd = e2_q[ch_q]; end
      3'd3:    begin coef = a1_i; opnd = y1_q[ch_q]; end
      3'd4:    begin coef = a0_i; opnd = y2_q[ch_q]; end
      default: begin coef = b2_i; opnd = ecur_q;     end
    endcase
    prod = coef * opnd;
  end

  always_comb begin
    acc_sh = acc_q >>> FRAC;
    if ((&acc_sh[ACC_W-1:REG_W-1]) || !(|acc_sh[ACC_W-1:REG_W-1])) begin
      ysat = acc_sh[REG_W-1:0];
    end else if (acc_sh[ACC_W-1]) begin
      ysat = {1'b1, {(REG_W-1){1'b0}}};
    end else begin
      ysat = {1'b0, {(REG_W-1){1'b1}}};
    end

    y_int      = ysat[REG_W-1:FRAC];
    period_ext = $signed({{(INT_W - CMP_W){1'b0}}, PWM_periodCounterValue_i});
    if (y_int[INT_W-1]) begin
      cmp_calc = '0;
    end else if (y_int >= period_ext) begin
      cmp_calc = PWM_periodCounterValue_i;
    end else begin
      cmp_calc = y_int[CMP_W-1:0];
    end
    if (cmp_calc != '0 && cmp_calc < {1'b0, PWM_minCounterValue_i}) begin
      cmp_calc = {1'b0, PWM_minCounterValue_i};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else if (clk_en_i) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (strobe && !config_en_i) state_d = ST_MAC;
      ST_MAC:   if (term_q == 3'(MAC_TERMS - 1)) state_d = ST_SAT;
      ST_SAT:   state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != ST_IDLE);
    wr_en  = (state_q == ST_WRITE);
  end

  always_comb begin
    term_d = term_q;
    ch_d   = ch_q;
    ecur_d = ecur_q;
    acc_d  = acc_q;
    y_d    = y_q;
    cmp_d  = cmp_q;
    sp_d   = sp_q;
    e1_d   = e1_q;
    e2_d   = e2_q;
    y1_d   = y1_q;
    y2_d   = y2_q;
    ovr_d  = strobe && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (strobe && config_en_i) begin
          sp_d[channel_i] = data_i;
          e1_d[channel_i] = '0;
          e2_d[channel_i] = '0;
          y1_d[channel_i] = '0;
          y2_d[channel_i] = '0;
        end else if (strobe) begin
          ch_d   = channel_i;
          ecur_d = err_fx;
          acc_d  = '0;
          term_d = '0;
        end
      end
      ST_MAC: begin
        acc_d  = acc_q + {{(ACC_W - PRD_W){prod[PRD_W-1]}}, prod};
        term_d = term_q + 3'd1;
      end
      ST_SAT: begin
        y_d   = ysat;
        cmp_d = cmp_calc;
      end
      ST_WRITE: begin
        e2_d[ch_q] = e1_q[ch_q];
        e1_d[ch_q] = ecur_q;
        y2_d[ch_q] = y1_q[ch_q];
        y1_d[ch_q] = y_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      term_q <= '0;
      ch_q   <= '0;
      ecur_q <= '0;
      acc_q  <= '0;
      y_q    <= '0;
      cmp_q  <= '0;
      sp_q   <= '{default: '0};
      e1_q   <= '{default: '0};
      e2_q   <= '{default: '0};
      y1_q   <= '{default: '0};
      y2_q   <= '{default: '0};
    end else if (clk_en_i) begin
      term_q <= term_d;
      ch_q   <= ch_d;
      ecur_q <= ecur_d;
      acc_q  <= acc_d;
      y_q    <= y_d;
      cmp_q  <= cmp_d;
      sp_q   <= sp_d;
      e1_q   <= e1_d;
      e2_q   <= e2_d;
      y1_q   <= y1_d;
      y2_q   <= y2_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun_o = ovr_q;

  fan_pwm_bank #(
    .CHANNELS (CHANNELS),
    .CMP_W    (CMP_W),
    .CH_W     (CH_W)
  ) u_pwm_bank (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clk_en_i (clk_en_i),
    .period_i (PWM_periodCounterValue_i),
    .wr_en_i  (wr_en),
    .wr_ch_i  (ch_q),
    .wr_cmp_i (cmp_q),
    .pin_o    (PWM_pin_o)
  );

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Bench for fan_ctrl_multi: directed scenarios plus randomized transactions
// checked against an integer-arithmetic model of the regulator and PWM.
module tb_fan_ctrl_multi;

  logic               clk = 1'b0;
  logic               rstn;
  logic               clk_en;
  logic [5:0]         data;
  logic [0:0]         chan;
  logic               strb;
  logic               cfg_en;
  logic signed [13:0] b2, b1, b0, a1, a0;
  logic [6:0]         period;
  logic [5:0]         minv;
  logic [1:0]         pin;
  logic               busy;
  logic               ovr;
  logic [3:0]         st;

  int n_cmp  = 0;
  int n_fail = 0;

  int     m_sp  [2];
  longint m_e1  [2];
  longint m_e2  [2];
  longint m_y1  [2];
  longint m_y2  [2];
  int     m_cmp [2];

  always #5 clk = ~clk;

  fan_ctrl_multi #(
    .CHANNELS      (2),
    .ADC_BITWIDTH  (6),
    .REG_BITWIDTH  (14),
    .FRAC_BITWIDTH (6)
  ) dut (
    .clk_i                    (clk),
    .rstn_i                   (rstn),
    .clk_en_i                 (clk_en),
    .data_i                   (data),
    .channel_i                (chan),
    .dataValid_STRB_i         (strb),
    .config_en_i              (cfg_en),
    .b2_i                     (b2),
    .b1_i                     (b1),
    .b0_i                     (b0),
    .a1_i                     (a1),
    .a0_i                     (a0),
    .PWM_periodCounterValue_i (period),
    .PWM_minCounterValue_i    (minv),
    .PWM_pin_o                (pin),
    .busy_o                   (busy),
    .overrun_o                (ovr),
    .state_o                  (st)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_sp[c] = 0; m_e1[c] = 0; m_e2[c] = 0; m_y1[c] = 0; m_y2[c] = 0; m_cmp[c] = 0;
    end
  endtask

  task automatic model_cfg(input int ch, input int sp);
    m_sp[ch] = sp;
    m_e1[ch] = 0; m_e2[ch] = 0; m_y1[ch] = 0; m_y2[ch] = 0;
  endtask

  // y[k] in Q.6 from the regulator equation, then compare = clamp(int(y)).
  task automatic model_run(input int ch, input int adc);
    longint e, s, y, c;
    e = longint'(m_sp[ch] - adc) * 64;
    s = longint'(b2) * e + longint'(b1) * m_e1[ch] + longint'(b0) * m_e2[ch]
      + longint'(a1) * m_y1[ch] + longint'(a0) * m_y2[ch];
    y = s >>> 6;
    if (y > 8191)  y = 8191;
    if (y < -8192) y = -8192;
    c = y >>> 6;
    if (c < 0) c = 0;
    if (c > longint'(period)) c = longint'(period);
    if (c > 0 && c < longint'(minv)) c = longint'(minv);
    m_e2[ch] = m_e1[ch]; m_e1[ch] = e;
    m_y2[ch] = m_y1[ch]; m_y1[ch] = y;
    m_cmp[ch] = int'(c);
  endtask

  task automatic strobe(input int ch, input int d, input bit cfg);
    cfg_en = cfg;
    data   = 6'(d);
    chan   = 1'(ch);
    strb   = 1'b1;
    @(negedge clk);
    strb   = 1'b0;
  endtask

  task automatic run_and_wait(input string tag, input int ch, input int adc);
    int cnt;
    strobe(ch, adc, 1'b0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cnt), 64'd7);
  endtask

  task automatic measure(output int h0, output int h1);
    int p;
    p = int'(period);
    repeat (p + 2) @(negedge clk);
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < p; i++) begin
      h0 += int'(pin[0]);
      h1 += int'(pin[1]);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    int h0, h1, pulses, ch, adc, e0, e1;
    rstn = 1'b0; clk_en = 1'b1; data = '0; chan = '0; strb = 1'b0; cfg_en = 1'b0;
    b2 = 14'sd64; b1 = '0; b0 = '0; a1 = '0; a0 = '0;
    period = 7'd76; minv = 6'd12;
    repeat (3) @(negedge clk);
    check("rst_pin", 64'(pin), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovr", 64'(ovr), 64'd0);
    check("rst_state_run", 64'(st), 64'hA);
    cfg_en = 1'b1;
    #1 check("rst_state_cfg", 64'(st), 64'hC);
    @(negedge clk);
    rstn = 1'b1;

    // Basic run: setpoint 40, ADC 10 -> compare 30.
    strobe(0, 40, 1'b1);
    check("cfg_busy_low", 64'(busy), 64'd0);
    cfg_en = 1'b0;
    #1 check("state_run", 64'(st), 64'hA);
    run_and_wait("r37", 0, 10);
    measure(h0, h1);
    check("r37_pin0_high", 64'(h0), 64'd30);
    check("r37_pin1_high", 64'(h1), 64'd0);

    // Minimum speed and negative error.
    run_and_wait("r38a", 0, 35);
    measure(h0, h1);
    check("r38_err5_min", 64'(h0), 64'd12);
    run_and_wait("r38b", 0, 43);
    measure(h0, h1);
    check("r38_errneg_off", 64'(h0), 64'd0);

    // Output saturation: compare clamps to the period.
    b2 = 14'sd8191;
    strobe(0, 63, 1'b1);
    run_and_wait("r39", 0, 0);
    measure(h0, h1);
    check("r39_sat_full", 64'(h0), 64'd76);
    b2 = 14'sd64;

    // Integrator via a1 = 1.0: outputs 2, 4, 6 raised to min, then exact.
    a1 = 14'sd64;
    strobe(0, 40, 1'b1);
    for (int k = 0; k < 3; k++) begin
      run_and_wait("r40a", 0, 38);
      measure(h0, h1);
      check("r40_min_clamped", 64'(h0), 64'd12);
    end
    minv = 6'd0;
    strobe(0, 40, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      run_and_wait("r40b", 0, 38);
      measure(h0, h1);
      check("r40_integrate", 64'(h0), 64'(2 * k));
    end
    a1 = '0;
    minv = 6'd12;

    // Strobe three cycles into an update is dropped with a single overrun pulse.
    strobe(0, 40, 1'b1);
    strobe(0, 10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    strobe(0, 20, 1'b0);
    check("r41_ovr_now", 64'(ovr), 64'd1);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      pulses += int'(ovr);
      @(negedge clk);
    end
    check("r41_ovr_pulses", 64'(pulses), 64'd1);
    measure(h0, h1);
    check("r41_first_kept", 64'(h0), 64'd30);

    // Reset in the middle of the MAC phase.
    strobe(0, 10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("r42_busy", 64'(busy), 64'd0);
    check("r42_pin", 64'(pin), 64'd0);
    check("r42_ovr", 64'(ovr), 64'd0);
    check("r42_state", 64'(st), 64'hA);
    @(negedge clk);
    rstn = 1'b1;
    strobe(0, 40, 1'b1);
    run_and_wait("r42", 0, 10);
    measure(h0, h1);
    check("r42_after_pin0", 64'(h0), 64'd30);
    check("r42_after_pin1", 64'(h1), 64'd0);

    // Randomized transactions against the model.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      adc = int'($urandom_range(63, 0));
      strobe(c, adc, 1'b1);
      model_cfg(c, adc);
    end
    for (int it = 0; it < 20; it++) begin
      period = 7'($urandom_range(100, 16));
      minv   = 6'($urandom_range(20, 0));
      b2 = 14'(int'($urandom_range(255, 0)) - 128);
      b1 = 14'(int'($urandom_range(255, 0)) - 128);
      b0 = 14'(int'($urandom_range(255, 0)) - 128);
      a1 = 14'(int'($urandom_range(127, 0)) - 64);
      a0 = 14'(int'($urandom_range(127, 0)) - 64);
      if ($urandom_range(4, 0) == 0) begin
        ch  = int'($urandom_range(1, 0));
        adc = int'($urandom_range(63, 0));
        strobe(ch, adc, 1'b1);
        model_cfg(ch, adc);
        check("rnd_cfg_busy", 64'(busy), 64'd0);
      end
      ch  = int'($urandom_range(1, 0));
      adc = int'($urandom_range(63, 0));
      run_and_wait("rnd", ch, adc);
      model_run(ch, adc);
      measure(h0, h1);
      e0 = (m_cmp[0] < int'(period)) ? m_cmp[0] : int'(period);
      e1 = (m_cmp[1] < int'(period)) ? m_cmp[1] : int'(period);
      check("rnd_pin0", 64'(h0), 64'(e0));
      check("rnd_pin1", 64'(h1), 64'(e1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
